// File: rtl/pbssw_pkg.sv
// Shared definitions for the push-button / slide-switch conditioning stage:
// channel state encodings, per-channel debug record and default timing.
package pbssw_pkg;

    typedef enum logic [1:0] {
        ST_LO  = 2'b00,
        ST_WHI = 2'b01,
        ST_WLO = 2'b10,
        ST_HI  = 2'b11
    } chan_state_t;

    // Per-channel observation record: FSM state plus the raw edge pulses
    // (switch channels have no pulse ports, so this is the only place they show).
    typedef struct packed {
        chan_state_t state;
        logic        rise;
        logic        fall;
    } chan_dbg_t;

    // 10 ms at 100 MHz
    localparam int DB_CYCLES_DEFAULT = 1000000;
    localparam int CNTW_DEFAULT      = 20;

endpackage

// File: rtl/db_chan.sv
// One debounce channel: 2-flop synchroniser, stability counter and a
// four-state FSM producing a clean level plus registered rise/fall pulses.
module db_chan
    import pbssw_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNTW      = CNTW_DEFAULT
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        raw,
    output logic        db,
    output logic        rise,
    output logic        fall,
    output chan_state_t state
);

    localparam logic [CNTW-1:0] TERM = CNTW'(DB_CYCLES - 1);

    logic            sync1;
    logic            s;
    logic [CNTW-1:0] cnt_q;
    logic [CNTW-1:0] cnt_d;
    chan_state_t     state_d;
    logic            db_d;
    logic            rise_d;
    logic            fall_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sync1 <= 1'b0;
            s     <= 1'b0;
            state <= ST_LO;
            cnt_q <= '0;
            db    <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            sync1 <= raw;
            s     <= sync1;
            state <= state_d;
            cnt_q <= cnt_d;
            db    <= db_d;
            rise  <= rise_d;
            fall  <= fall_d;
        end
    end

    // The stable-state cycle that first sees the new level counts as cycle 1,
    // so the level is accepted after exactly DB_CYCLES stable samples.
    always_comb begin
        state_d = state;
        cnt_d   = cnt_q;
        db_d    = db;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state)
            ST_LO: begin
                cnt_d = '0;
                db_d  = 1'b0;
                if (s) begin
                    state_d = ST_WHI;
                    cnt_d   = CNTW'(1);
                end
            end
            ST_WHI: begin
                if (!s) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                end else if (cnt_q == TERM) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                    db_d    = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            ST_HI: begin
                cnt_d = '0;
                db_d  = 1'b1;
                if (!s) begin
                    state_d = ST_WLO;
                    cnt_d   = CNTW'(1);
                end
            end
            ST_WLO: begin
                if (s) begin
                    state_d = ST_HI;
                    cnt_d   = '0;
                end else if (cnt_q == TERM) begin
                    state_d = ST_LO;
                    cnt_d   = '0;
                    db_d    = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            default: begin
                state_d = ST_LO;
                cnt_d   = '0;
                db_d    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pbssw_debounce.sv
// Conditioning stage in front of the button/switch LED latch: one independent
// debounce channel per button and per slide switch.
module pbssw_debounce
    import pbssw_pkg::*;
#(
    parameter int NBTN      = 2,
    parameter int NSW       = 8,
    parameter int DB_CYCLES = DB_CYCLES_DEFAULT,
    parameter int CNTW      = CNTW_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [NBTN-1:0]            btn_in,
    input  logic [NSW-1:0]             sw_in,
    output logic [NBTN-1:0]            btn_db,
    output logic [NBTN-1:0]            btn_rise,
    output logic [NBTN-1:0]            btn_fall,
    output logic [NSW-1:0]             sw_db,
    output chan_dbg_t [NBTN+NSW-1:0]   dbg
);

    for (genvar i = 0; i < NBTN; i++) begin : g_btn
        chan_state_t st;
        db_chan #(.DB_CYCLES(DB_CYCLES), .CNTW(CNTW)) u_chan (
            .clk   (clk),
            .rstn  (rstn),
            .raw   (btn_in[i]),
            .db    (btn_db[i]),
            .rise  (btn_rise[i]),
            .fall  (btn_fall[i]),
            .state (st)
        );
        assign dbg[i].state = st;
        assign dbg[i].rise  = btn_rise[i];
        assign dbg[i].fall  = btn_fall[i];
    end

    // Switch pulses are not ported; they only surface in the debug record.
    for (genvar j = 0; j < NSW; j++) begin : g_sw
        chan_state_t st;
        logic        r;
        logic        f;
        db_chan #(.DB_CYCLES(DB_CYCLES), .CNTW(CNTW)) u_chan (
            .clk   (clk),
            .rstn  (rstn),
            .raw   (sw_in[j]),
            .db    (sw_db[j]),
            .rise  (r),
            .fall  (f),
            .state (st)
        );
        assign dbg[NBTN+j].state = st;
        assign dbg[NBTN+j].rise  = r;
        assign dbg[NBTN+j].fall  = f;
    end

endmodule

// File: tb/tb_pbssw_debounce.sv
// Directed bench for pbssw_debounce with DB_CYCLES=4: expected button pulses
// are queued by the stimulus and matched by an independent monitor.
module tb_pbssw_debounce;
    import pbssw_pkg::*;

    localparam int NBTN = 2;
    localparam int NSW  = 8;
    localparam int DB   = 4;
    localparam int CNTW = 3;
    localparam int LAT  = DB + 2;
    localparam int EW   = 36;

    logic                     clk = 1'b0;
    logic                     rstn;
    logic [NBTN-1:0]          btn_in;
    logic [NSW-1:0]           sw_in;
    logic [NBTN-1:0]          btn_db;
    logic [NBTN-1:0]          btn_rise;
    logic [NBTN-1:0]          btn_fall;
    logic [NSW-1:0]           sw_db;
    chan_dbg_t [NBTN+NSW-1:0] dbg;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // entry = {cycle[31:0], rise[1:0], fall[1:0]}
    logic [EW-1:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pbssw_debounce #(.NBTN(NBTN), .NSW(NSW), .DB_CYCLES(DB), .CNTW(CNTW)) dut (
        .clk      (clk),
        .rstn     (rstn),
        .btn_in   (btn_in),
        .sw_in    (sw_in),
        .btn_db   (btn_db),
        .btn_rise (btn_rise),
        .btn_fall (btn_fall),
        .sw_db    (sw_db),
        .dbg      (dbg)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // driver tasks
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input logic [1:0] r, input logic [1:0] f);
        exp_q.push_back({32'(cyc + LAT), r, f});
    endtask

    task automatic check_all_zero(input string name);
        check(name, {16'h0, btn_db, btn_rise, btn_fall, sw_db}, 32'h0);
        for (int i = 0; i < NBTN + NSW; i++)
            check({name, "_state"}, 32'(dbg[i].state), 32'(ST_LO));
    endtask

    // scoreboard monitor
    initial begin
        logic [EW-1:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (rstn !== 1'b1) begin
                check("in_reset_outputs", {16'h0, btn_db, btn_rise, btn_fall, sw_db}, 32'h0);
            end else begin
                if (exp_q.size() > 0 && exp_q[0][35:4] < 32'(cyc)) begin
                    checks++;
                    failures++;
                    e = exp_q.pop_front();
                    $display("FAIL missed_pulse: no pulse observed, expected rise=%b fall=%b at cycle %0d",
                             e[3:2], e[1:0], e[35:4]);
                end
                if ((btn_rise | btn_fall) != '0) begin
                    check("rise_fall_exclusive", 32'(btn_rise & btn_fall), 32'h0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_pulse: rise=%b fall=%b expected none at cycle %0d",
                                 btn_rise, btn_fall, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("pulse_cycle", 32'(cyc), e[35:4]);
                        check("pulse_rise", 32'(btn_rise), 32'(e[3:2]));
                        check("pulse_fall", 32'(btn_fall), 32'(e[1:0]));
                    end
                end
            end
        end
    end

    // stimulus
    initial begin
        btn_in = '0;
        sw_in  = '0;
        rstn   = 1'b1;
        #1 rstn = 1'b0;

        // reset with random inputs
        repeat (3) begin
            @(negedge clk);
            btn_in = 2'($urandom_range(0, 3));
            sw_in  = 8'($urandom_range(0, 255));
            #1 check_all_zero("reset_outputs");
        end
        @(negedge clk);
        btn_in = '0;
        sw_in  = '0;
        rstn   = 1'b1;
        repeat (20) begin
            @(negedge clk);
            check("idle_levels", {22'h0, btn_db, sw_db}, 32'h0);
        end

        // clean press and release on BTNL
        @(negedge clk);
        btn_in[0] = 1'b1;
        expect_pulse(2'b01, 2'b00);
        tick(4);
        check("press_db_not_yet", 32'(btn_db), 32'h0);
        tick(3);
        check("press_db", 32'(btn_db), 32'h1);
        @(negedge clk);
        btn_in[0] = 1'b0;
        expect_pulse(2'b00, 2'b01);
        tick(8);
        check("release_db", 32'(btn_db), 32'h0);

        // bouncing BTNR: 1,0,1,0 for two cycles each, then hold 1
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            btn_in[1] = (k % 2 == 0);
            tick(1);
        end
        @(negedge clk);
        btn_in[1] = 1'b1;
        expect_pulse(2'b10, 2'b00);
        tick(8);
        check("bounce_db", 32'(btn_db), 32'h2);
        @(negedge clk);
        btn_in[1] = 1'b0;
        expect_pulse(2'b00, 2'b10);
        tick(8);

        // 3-cycle glitch on SW[3] under a steady pattern
        @(negedge clk);
        sw_in = 8'hA5;
        tick(8);
        check("sw_pattern", 32'(sw_db), 32'hA5);
        @(negedge clk);
        sw_in[3] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (i == 2) sw_in[3] = 1'b0;
            check("glitch_sw_db", 32'(sw_db), 32'hA5);
        end

        // simultaneous events on all channels
        @(negedge clk);
        sw_in = 8'h00;
        tick(8);
        check("sw_cleared", 32'(sw_db), 32'h0);
        @(negedge clk);
        btn_in = 2'b11;
        sw_in  = 8'hFF;
        expect_pulse(2'b11, 2'b00);
        tick(5);
        check("sw_before_accept", 32'(sw_db), 32'h0);
        tick(1);
        check("sw_same_cycle", 32'(sw_db), 32'hFF);
        check("btn_same_cycle", 32'(btn_db), 32'h3);
        @(negedge clk);
        btn_in = 2'b00;
        expect_pulse(2'b00, 2'b11);
        tick(8);

        // reset in the middle of a BTNL wait, BTNR already high
        @(negedge clk);
        btn_in[1] = 1'b1;
        expect_pulse(2'b10, 2'b00);
        tick(8);
        check("pre_reset_db", 32'(btn_db), 32'h2);
        @(negedge clk);
        btn_in[0] = 1'b1;
        tick(4);
        rstn = 1'b0;
        #1 check_all_zero("midwait_reset");
        check("midwait_queue_empty", 32'(exp_q.size()), 32'h0);
        tick(3);
        @(negedge clk);
        rstn = 1'b1;
        expect_pulse(2'b11, 2'b00);
        tick(8);
        check("post_reset_db", 32'(btn_db), 32'h3);

        tick(4);
        check("queue_drained", 32'(exp_q.size()), 32'h0);

        // final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
